// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiply / restoring divide with HI/LO registers
module mul_div_unit #(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0] m_q, m_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem;
  logic [WIDTH:0] mul_sum, rem_sh, diff;
  logic div_q, div_d, sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d, done_q, done_d;
  logic signed_op, is_md, neg_res;
  assign signed_op = ~op_i[0];
  assign is_md     = ~op_i[2] & (~op_i[1] | DIV_EN);
  assign abs_a     = (signed_op & a_i[WIDTH-1]) ? -a_i : a_i;
  assign abs_b     = (signed_op & b_i[WIDTH-1]) ? -b_i : b_i;
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff      = rem_sh - {1'b0, m_q};
  assign neg_res   = sgn_q & (sa_q ^ sb_q);
  assign prod      = neg_res ? -acc_q : acc_q;
  assign quo       = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem       = (sgn_q & sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && is_md) begin
          state_d = CALC;
          cnt_d   = CW'(WIDTH);
          acc_d   = {{WIDTH{1'b0}}, op_i[1] ? abs_a : abs_b};
          m_d     = op_i[1] ? abs_b : abs_a;
          a_d     = a_i;
          div_d   = op_i[1];
          sgn_d   = signed_op;
          sa_d    = a_i[WIDTH-1];
          sb_d    = b_i[WIDTH-1];
        end
        hi_d = (start_i && op_i == 3'b100) ? a_i : hi_q;
        lo_d = (start_i && op_i == 3'b101) ? a_i : lo_q;
      end
      CALC: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? FIX : CALC;
        // divide: keep the shifted remainder when the trial subtract borrows
        acc_d   = !div_q ? {mul_sum, acc_q[WIDTH-1:1]} :
                  diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                                {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        hi_d    = !div_q ? prod[2*WIDTH-1:WIDTH] : (m_q == '0) ? a_q : rem;
        lo_d    = !div_q ? prod[WIDTH-1:0] : (m_q == '0) ? {WIDTH{1'b1}} : quo;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      done_q  <= done_d;
    end
  end
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule
